traffic_light_ctrl: RTL and testbench
=====================================

# traffic_light_ctrl

Parametrised four-way intersection controller, the next generation of the fixed-timing `traffic_light` FSM. It drives north/south/east/west lamp heads from a prescaled phase timer with configurable green, yellow and all-red durations. It adds per-axis pedestrian requests with green extension, emergency-vehicle preemption, and an optional night-flash mode. It sits directly under the intersection top level, with lamp outputs going straight to the pad drivers.

## Interface
- `TICK_DIV`, 1000: clk cycles per timer tick; ≥1.
- `GREEN_T`, 8: green duration in ticks.
- `YELLOW_T`, 3: yellow duration in ticks.
- `ALLRED_T`, 2: all-red clearance in ticks.
- `PED_EXT`, 4: extra green ticks when a pedestrian request is latched.
- `CNT_W`, 8: phase timer width. Durations of 0 are treated as 1.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `ped_req_ns`, `ped_req_ew` in 1: pedestrian request, one per axis; level or pulse.
- `emerg_req` in 1: emergency preemption request, level.
- `emerg_dir` in 1: 0 = NS axis, 1 = EW axis; sampled while `emerg_req` is high.
- `night_mode` in 1: request flash operation; ignored unless `TL_NIGHT_FLASH_EN` is defined.
- `north_light`, `south_light`, `east_light`, `west_light` out 3: {red, yellow, green}. Encodings: 100 = red, 010 = yellow, 001 = green, 000 = dark.
- `walk_ns`, `walk_ew` out 1: walk lamp for the axis.
- `emerg_ack` out 1: preemption green is being held.
- `state` out 3: current phase, encoded below.

## Operation
- Phases and encodings:
  - NS_G = 0
  - NS_Y = 1
  - AR_A = 2
  - EW_G = 3
  - EW_Y = 4
  - AR_B = 5
  - FLASH = 6
- Normal sequence: AR_B → NS_G → NS_Y → AR_A → EW_G → EW_Y → AR_B.
- N and S always show identical lamps; E and W always show identical lamps.
  - Axis in G: green. Axis in Y: yellow. Otherwise red.
- Phase timer:
  - Loads duration−1 on phase entry.
  - Decrements on each tick.
  - The phase exits on the clk edge where tick is set and timer = 0.
- Prescaler:
  - Free-running from 0 to TICK_DIV−1; tick is asserted on the terminal count.
  - Not reset by phase changes.
- Pedestrian requests:
  - `ped_req_xx` sets a sticky latch.
  - If the latch is set on entry to the axis green, or at any time during it, the green is extended by PED_EXT ticks once per phase and `walk_xx` = 1 for the whole green.
  - The latch clears on exit of that axis's green.
  - A request arriving during the same axis's yellow or all-red is served in the next green of that axis.
- Emergency preemption (priority over pedestrian and night requests):
  - Green of the non-requested axis: forced to Y on the next clk edge, then normal Y and AR timing.
  - The AR phase that follows always leads to the requested axis's green, skipping the other green if necessary.
  - Requested axis's green: timer frozen, `emerg_ack` = 1, `walk` = 0, held while `emerg_req` = 1.
  - On release: timer forced to 0, so the phase exits at the next tick.
  - Pedestrian latches are preserved during preemption.
- Reset:
  - State AR_B with timer = ALLRED_T−1 and prescaler = 0.
  - All lamps 100.
  - walk = 0, `emerg_ack` = 0, latches cleared.
- Reset asserted mid-phase returns to the reset state immediately (asynchronously).

## Timing
- All outputs are registered and follow state with no extra cycle.
- With TICK_DIV = 1, a phase lasts exactly its duration in clk cycles.
- Inputs are sampled on the rising clk edge. Inputs are assumed synchronous; synchronisers live at the top level.
- Simultaneous events:
  - Preemption wins over the normal end of a phase.
  - A pedestrian request on the exit edge of a green is latched for the next green of that axis.

## Configuration
- Macro: `TL_NIGHT_FLASH_EN`.
- Defined:
  - `night_mode` = 1 at the exit of AR_A or AR_B enters FLASH instead of a green.
  - In FLASH, all four lamps alternate 010 / 000 each tick, starting at 010; walk = 0.
  - `night_mode` = 0 exits to AR_B, then NS_G.
  - `emerg_req` in FLASH exits to AR_B, then the requested green.
- Undefined: FLASH is unreachable and `night_mode` is ignored. The port remains for a stable top-level interface.

## Test plan
- Normal cycle. Parameters TICK_DIV = 1, GREEN_T = 8, YELLOW_T = 3, ALLRED_T = 2. Release reset at cycle 0 → AR_B for 2 cycles, NS_G for 8, NS_Y for 3, AR_A for 2, EW_G for 8; period 26 cycles; N/S = 001 while E/W = 100 during NS_G.
- Pedestrian: 1-cycle `ped_req_ew` pulse during NS_G → EW_G lasts 12 cycles with `walk_ew` = 1 throughout; the following EW_G lasts 8 cycles.
- Preemption: `emerg_req` = 1, `emerg_dir` = 1 at cycle 4 of NS_G → NS_Y on the next edge, 3 cycles; AR_A 2 cycles; EW_G held with `emerg_ack` = 1. Drop `emerg_req` → EW_Y one tick later.
- Preemption of the already-green axis: `emerg_dir` = 0 during NS_G → state stays 0 and the timer is frozen for 20 cycles.
- Reset during EW_Y → lamps immediately 100, state 5, walk = 0.
- Night flash (macro defined): `night_mode` = 1 → FLASH after the next AR; lamps toggle 010/000 each tick. Clear `night_mode` → AR_B for 2 cycles, then NS_G.

Source files
------------

// File: rtl/traffic_light_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_light_ctrl
//
// Four-way intersection controller. North/south share one lamp head value and
// east/west share another. A free-running prescaler produces a timer tick
// every TICK_DIV clocks; each phase runs for a configured number of ticks.
//
// Features:
//   - Pedestrian request latch per axis. A latched request extends that
//     axis's green by PED_EXT ticks (once per green) and lights its walk lamp.
//   - Emergency preemption. The conflicting green is cut to yellow at once.
//     The next all-red leads to the requested green, which is then held for
//     as long as emerg_req stays high.
//   - Optional night flash, compiled in only when TL_NIGHT_FLASH_EN is
//     defined. Without the macro the FLASH phase is unreachable and
//     night_mode is ignored.
//
// Parameters:
//   TICK_DIV  clk cycles per timer tick (>= 1)
//   GREEN_T   green duration in ticks
//   YELLOW_T  yellow duration in ticks
//   ALLRED_T  all-red clearance in ticks
//   PED_EXT   extra green ticks for a served pedestrian request
//   CNT_W     phase timer width
//   A duration of 0 is treated as 1.
//
// Ports:
//   clk                     system clock, rising edge
//   reset                   asynchronous, active-high reset
//   ped_req_ns, ped_req_ew  pedestrian requests (level or pulse)
//   emerg_req, emerg_dir    preemption request; dir 0 = NS, 1 = EW
//   night_mode              flash request (needs TL_NIGHT_FLASH_EN)
//   north/south/east/west_light  {red, yellow, green} lamp drive
//   walk_ns, walk_ew        walk lamps
//   emerg_ack               preemption green is being held
//   state                   current phase code
// -----------------------------------------------------------------------------
module traffic_light_ctrl #(
   parameter int TICK_DIV = 1000,
   parameter int GREEN_T  = 8,
   parameter int YELLOW_T = 3,
   parameter int ALLRED_T = 2,
   parameter int PED_EXT  = 4,
   parameter int CNT_W    = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ped_req_ns,
   input  logic       ped_req_ew,
   input  logic       emerg_req,
   input  logic       emerg_dir,
   input  logic       night_mode,
   output logic [2:0] north_light,
   output logic [2:0] south_light,
   output logic [2:0] east_light,
   output logic [2:0] west_light,
   output logic       walk_ns,
   output logic       walk_ew,
   output logic       emerg_ack,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_NS_G  = 3'd0,
      S_NS_Y  = 3'd1,
      S_AR_A  = 3'd2,
      S_EW_G  = 3'd3,
      S_EW_Y  = 3'd4,
      S_AR_B  = 3'd5,
      S_FLASH = 3'd6
   } phase_t;

   localparam logic [2:0] LAMP_R   = 3'b100;
   localparam logic [2:0] LAMP_Y   = 3'b010;
   localparam logic [2:0] LAMP_G   = 3'b001;
   localparam logic [2:0] LAMP_OFF = 3'b000;

   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] L_PRE_TC = PRE_W'(TICK_DIV - 1);

   // Zero durations behave as one tick
   localparam int G_D  = (GREEN_T  < 1) ? 1 : GREEN_T;
   localparam int Y_D  = (YELLOW_T < 1) ? 1 : YELLOW_T;
   localparam int AR_D = (ALLRED_T < 1) ? 1 : ALLRED_T;

   localparam logic [CNT_W-1:0] L_G   = CNT_W'(G_D - 1);
   localparam logic [CNT_W-1:0] L_GX  = CNT_W'(G_D - 1 + PED_EXT);
   localparam logic [CNT_W-1:0] L_Y   = CNT_W'(Y_D - 1);
   localparam logic [CNT_W-1:0] L_AR  = CNT_W'(AR_D - 1);
   localparam logic [CNT_W-1:0] L_EXT = CNT_W'(PED_EXT);

   // State and control registers
   phase_t           r_state;
   logic [CNT_W-1:0] r_tmr;
   logic [PRE_W-1:0] r_pre;
   logic             r_ped_ns;
   logic             r_ped_ew;
   logic             r_ext;     // green already extended for pedestrians
   logic             r_emg;     // current green has been held by preemption
   logic             r_blink;   // flash lamps lit

   // Registered outputs
   logic [2:0]       r_ns_lamp;
   logic [2:0]       r_ew_lamp;
   logic             r_walk_ns;
   logic             r_walk_ew;
   logic             r_ack;

   // Next-state and helper signals
   phase_t           w_state_nxt;
   logic [CNT_W-1:0] w_tmr_nxt;
   logic [CNT_W-1:0] w_tmr_dec;
   logic [CNT_W-1:0] w_tick_v;
   logic             w_ped_ns_nxt;
   logic             w_ped_ew_nxt;
   logic             w_ext_nxt;
   logic             w_emg_nxt;
   logic             w_blink_nxt;
   logic             w_tick;
   logic             w_expire;
   logic             w_ew_axis;
   logic             w_own_ped;
   logic             w_pre_here;
   logic             w_pre_other;
   logic             w_leave_green;
   logic             w_enter_green;
   logic             w_green_axis;
   logic             w_night_go;
   logic [2:0]       w_ns_lamp;
   logic [2:0]       w_ew_lamp;
   logic             w_walk_ns_nxt;
   logic             w_walk_ew_nxt;
   logic             w_ack_nxt;

`ifdef TL_NIGHT_FLASH_EN
   assign w_night_go = night_mode;
`else
   logic w_unused_night;
   assign w_unused_night = night_mode;
   assign w_night_go     = 1'b0;
`endif

   assign w_tick    = (r_pre == L_PRE_TC);
   assign w_tick_v  = {{(CNT_W-1){1'b0}}, w_tick};
   assign w_tmr_dec = r_tmr - w_tick_v;
   assign w_expire  = w_tick && (r_tmr == '0);

   // Green-phase qualifiers; only meaningful while in NS_G or EW_G
   assign w_ew_axis   = (r_state == S_EW_G);
   assign w_own_ped   = w_ew_axis ? r_ped_ew : r_ped_ns;
   assign w_pre_here  = emerg_req && (emerg_dir == w_ew_axis);
   assign w_pre_other = emerg_req && (emerg_dir != w_ew_axis);

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_nxt   = r_state;
      w_tmr_nxt     = r_tmr;
      w_ext_nxt     = r_ext;
      w_emg_nxt     = r_emg;
      w_blink_nxt   = r_blink;
      w_ped_ns_nxt  = r_ped_ns | ped_req_ns;
      w_ped_ew_nxt  = r_ped_ew | ped_req_ew;
      w_leave_green = 1'b0;
      w_enter_green = 1'b0;
      w_green_axis  = 1'b0;

      case (r_state)
         S_NS_G, S_EW_G: begin
            if (w_pre_other) begin
               // Conflicting preemption cuts this green immediately
               w_leave_green = 1'b1;
            end else if (w_pre_here) begin
               // Held green: timer frozen until the request drops
               w_emg_nxt = 1'b1;
            end else if (r_emg) begin
               // Released hold: park the timer at 0 so the next tick exits
               if (w_expire) begin
                  w_leave_green = 1'b1;
               end else begin
                  w_tmr_nxt = '0;
               end
            end else if (w_own_ped && !r_ext) begin
               // Pending extension outranks a simultaneous expiry
               w_tmr_nxt = r_tmr + L_EXT - w_tick_v;
               w_ext_nxt = 1'b1;
            end else if (w_expire) begin
               w_leave_green = 1'b1;
            end else begin
               w_tmr_nxt = w_tmr_dec;
            end
         end

         S_NS_Y: begin
            if (w_expire) begin
               w_state_nxt = S_AR_A;
               w_tmr_nxt   = L_AR;
            end else begin
               w_tmr_nxt = w_tmr_dec;
            end
         end

         S_EW_Y: begin
            if (w_expire) begin
               w_state_nxt = S_AR_B;
               w_tmr_nxt   = L_AR;
            end else begin
               w_tmr_nxt = w_tmr_dec;
            end
         end

         S_AR_A, S_AR_B: begin
            if (w_expire) begin
               if (w_night_go && !emerg_req) begin
                  w_state_nxt = S_FLASH;
                  w_blink_nxt = 1'b1;
               end else begin
                  // A pending preemption picks the green; otherwise alternate
                  w_enter_green = 1'b1;
                  w_green_axis  = emerg_req ? emerg_dir : (r_state == S_AR_A);
               end
            end else begin
               w_tmr_nxt = w_tmr_dec;
            end
         end

`ifdef TL_NIGHT_FLASH_EN
         S_FLASH: begin
            if (emerg_req || !w_night_go) begin
               w_state_nxt = S_AR_B;
               w_tmr_nxt   = L_AR;
               w_blink_nxt = 1'b0;
            end else if (w_tick) begin
               w_blink_nxt = ~r_blink;
            end
         end
`endif

         default: begin
            w_state_nxt = S_AR_B;
            w_tmr_nxt   = L_AR;
            w_ext_nxt   = 1'b0;
            w_emg_nxt   = 1'b0;
            w_blink_nxt = 1'b0;
         end
      endcase

      if (w_leave_green) begin
         w_state_nxt = w_ew_axis ? S_EW_Y : S_NS_Y;
         w_tmr_nxt   = L_Y;
         w_ext_nxt   = 1'b0;
         w_emg_nxt   = 1'b0;
         // A served request is cleared; one never served survives.
         // A request on this very edge is kept for the next green.
         if (w_ew_axis) begin
            w_ped_ew_nxt = ped_req_ew | (r_ped_ew & (~r_ext | r_emg));
         end else begin
            w_ped_ns_nxt = ped_req_ns | (r_ped_ns & (~r_ext | r_emg));
         end
      end

      if (w_enter_green) begin
         w_state_nxt = w_green_axis ? S_EW_G : S_NS_G;
         w_emg_nxt   = emerg_req;
         w_ext_nxt   = !emerg_req && (w_green_axis ? r_ped_ew : r_ped_ns);
         w_tmr_nxt   = w_ext_nxt ? L_GX : L_G;
      end
   end

   // -------------------------------------------------------------------------
   // Output decode from the next state so registered lamps track state
   // -------------------------------------------------------------------------
   always_comb begin
      w_ns_lamp = LAMP_R;
      w_ew_lamp = LAMP_R;
      case (w_state_nxt)
         S_NS_G:  w_ns_lamp = LAMP_G;
         S_NS_Y:  w_ns_lamp = LAMP_Y;
         S_EW_G:  w_ew_lamp = LAMP_G;
         S_EW_Y:  w_ew_lamp = LAMP_Y;
         S_FLASH: begin
            w_ns_lamp = w_blink_nxt ? LAMP_Y : LAMP_OFF;
            w_ew_lamp = w_blink_nxt ? LAMP_Y : LAMP_OFF;
         end
         default: ;
      endcase
   end

   assign w_walk_ns_nxt = (w_state_nxt == S_NS_G) && w_ext_nxt && !w_emg_nxt;
   assign w_walk_ew_nxt = (w_state_nxt == S_EW_G) && w_ext_nxt && !w_emg_nxt;
   assign w_ack_nxt     = emerg_req &&
                          (((w_state_nxt == S_NS_G) && !emerg_dir) ||
                           ((w_state_nxt == S_EW_G) &&  emerg_dir));

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_AR_B;
         r_tmr     <= L_AR;
         r_pre     <= '0;
         r_ped_ns  <= 1'b0;
         r_ped_ew  <= 1'b0;
         r_ext     <= 1'b0;
         r_emg     <= 1'b0;
         r_blink   <= 1'b0;
         r_ns_lamp <= LAMP_R;
         r_ew_lamp <= LAMP_R;
         r_walk_ns <= 1'b0;
         r_walk_ew <= 1'b0;
         r_ack     <= 1'b0;
      end else begin
         // Prescaler runs freely, independent of phase changes
         r_pre     <= w_tick ? '0 : r_pre + PRE_W'(1);
         r_state   <= w_state_nxt;
         r_tmr     <= w_tmr_nxt;
         r_ped_ns  <= w_ped_ns_nxt;
         r_ped_ew  <= w_ped_ew_nxt;
         r_ext     <= w_ext_nxt;
         r_emg     <= w_emg_nxt;
         r_blink   <= w_blink_nxt;
         r_ns_lamp <= w_ns_lamp;
         r_ew_lamp <= w_ew_lamp;
         r_walk_ns <= w_walk_ns_nxt;
         r_walk_ew <= w_walk_ew_nxt;
         r_ack     <= w_ack_nxt;
      end
   end

   assign north_light = r_ns_lamp;
   assign south_light = r_ns_lamp;
   assign east_light  = r_ew_lamp;
   assign west_light  = r_ew_lamp;
   assign walk_ns     = r_walk_ns;
   assign walk_ew     = r_walk_ew;
   assign emerg_ack   = r_ack;
   assign state       = r_state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for traffic_light_ctrl (TICK_DIV = 1, 8/3/2 tick phases, PED_EXT 4)
// plus a second instance with TICK_DIV = 3 to exercise the prescaler.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_traffic_light_ctrl;

   localparam int PED = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       ped_req_ns, ped_req_ew, emerg_req, emerg_dir, night_mode;
   logic [2:0] north_light, south_light, east_light, west_light, state;
   logic       walk_ns, walk_ew, emerg_ack;
   logic [2:0] d2_north, d2_south, d2_east, d2_west, d2_state;
   logic       d2_walk_ns, d2_walk_ew, d2_ack;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   traffic_light_ctrl #(
      .TICK_DIV(1), .GREEN_T(8), .YELLOW_T(3), .ALLRED_T(2), .PED_EXT(PED), .CNT_W(8)
   ) dut (
      .clk(clk), .reset(reset),
      .ped_req_ns(ped_req_ns), .ped_req_ew(ped_req_ew),
      .emerg_req(emerg_req), .emerg_dir(emerg_dir), .night_mode(night_mode),
      .north_light(north_light), .south_light(south_light),
      .east_light(east_light), .west_light(west_light),
      .walk_ns(walk_ns), .walk_ew(walk_ew), .emerg_ack(emerg_ack), .state(state)
   );

   traffic_light_ctrl #(
      .TICK_DIV(3), .GREEN_T(8), .YELLOW_T(3), .ALLRED_T(2), .PED_EXT(PED), .CNT_W(8)
   ) dut2 (
      .clk(clk), .reset(reset),
      .ped_req_ns(ped_req_ns), .ped_req_ew(ped_req_ew),
      .emerg_req(emerg_req), .emerg_dir(emerg_dir), .night_mode(night_mode),
      .north_light(d2_north), .south_light(d2_south),
      .east_light(d2_east), .west_light(d2_west),
      .walk_ns(d2_walk_ns), .walk_ew(d2_walk_ew), .emerg_ack(d2_ack), .state(d2_state)
   );

   typedef struct {
      logic [2:0] st;
      logic [2:0] ns;
      logic [2:0] ew;
   } vec_t;

   vec_t tbl[$];

   // ---------------- helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int obs();
      return int'({14'd0, state, north_light, south_light, east_light, west_light,
                   walk_ns, walk_ew, emerg_ack});
   endfunction

   function automatic int pack_exp(logic [2:0] st, logic [2:0] ns, logic [2:0] ew,
                                   logic wn, logic we, logic ack);
      return int'({14'd0, st, ns, ns, ew, ew, wn, we, ack});
   endfunction

   task automatic add(input int n, input logic [2:0] st, input logic [2:0] ns,
                      input logic [2:0] ew);
      vec_t v;
      v.st = st; v.ns = ns; v.ew = ew;
      for (int i = 0; i < n; i++) tbl.push_back(v);
   endtask

   task automatic wait_state(input int s, input int budget);
      int n;
      n = 0;
      while (int'(state) != s && n < budget) begin
         step();
         n++;
      end
      chk($sformatf("wait_state_%0d", s), int'(state), s);
   endtask

   // Counts consecutive samples spent in phase s and how many showed walk
   task automatic measure(input int s, output int cnt, output int wcnt);
      cnt  = 0;
      wcnt = 0;
      while (int'(state) == s && cnt < 200) begin
         cnt++;
         if ((s == 0 && walk_ns) || (s == 3 && walk_ew)) wcnt++;
         step();
      end
   endtask

   // ---------------- reference model (phase ages and lengths) ----------------
   int m_ph, m_age, m_len;
   bit m_ext, m_lat_ns, m_lat_ew;

   function automatic int dur(int ph);
      if (ph == 0 || ph == 3) return 8;
      if (ph == 1 || ph == 4) return 3;
      return 2;
   endfunction

   function automatic logic [2:0] lamp_ns(int ph);
      if (ph == 0) return 3'b001;
      if (ph == 1) return 3'b010;
      return 3'b100;
   endfunction

   function automatic logic [2:0] lamp_ew(int ph);
      if (ph == 3) return 3'b001;
      if (ph == 4) return 3'b010;
      return 3'b100;
   endfunction

   task automatic model_reset();
      m_ph = 5; m_age = 0; m_len = 2; m_ext = 0; m_lat_ns = 0; m_lat_ew = 0;
   endtask

   task automatic model_edge(input bit pns, input bit pew);
      if (m_ph == 0 && !m_ext && m_lat_ns) begin m_len += PED; m_ext = 1; end
      if (m_ph == 3 && !m_ext && m_lat_ew) begin m_len += PED; m_ext = 1; end
      m_age++;
      if (m_age >= m_len) begin
         if (m_ph == 0) m_lat_ns = 0;
         if (m_ph == 3) m_lat_ew = 0;
         m_ph  = (m_ph + 1) % 6;
         m_age = 0;
         m_len = dur(m_ph);
         m_ext = 0;
         if (m_ph == 0 && m_lat_ns) begin m_len += PED; m_ext = 1; end
         if (m_ph == 3 && m_lat_ew) begin m_len += PED; m_ext = 1; end
      end
      m_lat_ns = m_lat_ns | pns;
      m_lat_ew = m_lat_ew | pew;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- test ----------------
   initial begin
      int cnt, wcnt, hold, d2_ar, d2_g;
      bit pns, pew;

      reset = 1'b1; ped_req_ns = 0; ped_req_ew = 0;
      emerg_req = 0; emerg_dir = 0; night_mode = 0;

      // Normal cycle expectations, one record per clock after reset release
      add(1, 3'd5, 3'b100, 3'b100);
      add(8, 3'd0, 3'b001, 3'b100);
      add(3, 3'd1, 3'b010, 3'b100);
      add(2, 3'd2, 3'b100, 3'b100);
      add(8, 3'd3, 3'b100, 3'b001);
      add(3, 3'd4, 3'b100, 3'b010);
      add(2, 3'd5, 3'b100, 3'b100);
      add(1, 3'd0, 3'b001, 3'b100);

      repeat (3) @(posedge clk);
      #1;
      chk("reset_state", obs(), pack_exp(3'd5, 3'b100, 3'b100, 0, 0, 0));
      reset = 1'b0;

      d2_ar = 0; d2_g = 0;
      for (int i = 0; i < tbl.size(); i++) begin
         step();
         chk($sformatf("normal_cycle[%0d]", i), obs(),
             pack_exp(tbl[i].st, tbl[i].ns, tbl[i].ew, 0, 0, 0));
         if (d2_state == 3'd5) d2_ar++;
         if (d2_state == 3'd0) d2_g++;
      end
      chk("div3_allred_samples", d2_ar, 5);
      chk("div3_green_samples", d2_g, 23);

      // Pedestrian pulse during NS_G extends the following EW_G
      wait_state(0, 40);
      ped_req_ew = 1'b1;
      step();
      ped_req_ew = 1'b0;
      wait_state(3, 40);
      measure(3, cnt, wcnt);
      chk("ped_ew_green_len", cnt, 12);
      chk("ped_ew_walk_cycles", wcnt, 12);
      wait_state(3, 40);
      measure(3, cnt, wcnt);
      chk("ped_ew_next_green_len", cnt, 8);
      chk("ped_ew_next_walk", wcnt, 0);

      // Preemption toward EW arriving in the 4th cycle of NS_G
      wait_state(0, 40);
      repeat (3) step();
      emerg_req = 1'b1; emerg_dir = 1'b1;
      step();
      chk("preempt_forced_yellow", int'(state), 1);
      measure(1, cnt, wcnt);
      chk("preempt_yellow_len", cnt, 3);
      measure(2, cnt, wcnt);
      chk("preempt_allred_len", cnt, 2);
      chk("preempt_hold_entry", obs(), pack_exp(3'd3, 3'b100, 3'b001, 0, 0, 1));
      hold = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (state == 3'd3 && emerg_ack) hold++;
      end
      chk("preempt_hold_cycles", hold, 10);
      emerg_req = 1'b0;
      step();
      chk("preempt_release_state", int'(state), 3);
      chk("preempt_release_ack", int'(emerg_ack), 0);
      step();
      chk("preempt_release_exit", int'(state), 4);

      // Preemption of the axis that is already green
      wait_state(0, 60);
      emerg_req = 1'b1; emerg_dir = 1'b0;
      hold = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (state == 3'd0 && emerg_ack && !walk_ns) hold++;
      end
      chk("same_axis_hold", hold, 20);
      emerg_req = 1'b0;
      step();
      chk("same_axis_release_state", int'(state), 0);
      step();
      chk("same_axis_release_exit", int'(state), 1);

      // Asynchronous reset in the middle of EW_Y
      wait_state(4, 60);
      #2;
      reset = 1'b1;
      #1;
      chk("async_reset", obs(), pack_exp(3'd5, 3'b100, 3'b100, 0, 0, 0));
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();

      // Random pedestrian traffic against the phase-level model
      for (int i = 0; i < 600; i++) begin
         pns = ($urandom_range(0, 15) == 0);
         pew = ($urandom_range(0, 15) == 0);
         ped_req_ns = pns;
         ped_req_ew = pew;
`ifndef TL_NIGHT_FLASH_EN
         night_mode = $urandom_range(0, 1) == 1;
`endif
         step();
         model_edge(pns, pew);
         chk($sformatf("random[%0d]", i), obs(),
             pack_exp(3'(m_ph), lamp_ns(m_ph), lamp_ew(m_ph),
                      (m_ph == 0) && m_ext, (m_ph == 3) && m_ext, 0));
      end
      ped_req_ns = 0; ped_req_ew = 0; night_mode = 0;

`ifdef TL_NIGHT_FLASH_EN
      night_mode = 1'b1;
      wait_state(6, 60);
      chk("flash_on", int'({north_light, east_light}), int'(6'b010010));
      step();
      chk("flash_off", int'({north_light, east_light}), 0);
      step();
      chk("flash_on_again", int'({north_light, east_light, walk_ns, walk_ew}),
          int'(8'b01001000));
      night_mode = 1'b0;
      step();
      chk("flash_exit_ar1", int'(state), 5);
      step();
      chk("flash_exit_ar2", int'(state), 5);
      step();
      chk("flash_exit_green", int'(state), 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
